// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and helpers.
// Used by both initiator and target blocks.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AxSIZE encoding for a full-width beat of the given bus width.
    function automatic logic [2:0] size_from_width(input int width);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++)
            if ((8 << i) == width)
                s = 3'(i);
        return s;
    endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bus bundle with initiator and target views.
// Sideband fields beyond the core handshake are carried at fixed width.
interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst,
        output awlock, awcache, awprot, awqos, awregion,
        output awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arqos, arregion,
        output arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst,
        input awlock, awcache, awprot, awqos, awregion,
        input awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst,
        input arlock, arcache, arprot, arqos, arregion,
        input arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/axi_beat_counter.sv
// Burst beat counter: clear on accept, count handshakes, flag beat == len.
// Saturates so an overlong burst never wraps back onto the last beat.
module axi_beat_counter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] len,
    output logic       last
);
    logic [8:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt <= 9'd0;
        else if (clr)
            cnt <= 9'd0;
        else if (inc && cnt != 9'h1ff)
            cnt <= cnt + 9'd1;
    end

    assign last = (cnt == {1'b0, len});

endmodule

// File: rtl/axi_cmd_master.sv
// AXI4 initiator: one INCR burst outstanding, driven from simple
// command / write-data / read-data / response streams.
module axi_cmd_master
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_WIDTH-1:0]   wd_data,
    input  logic [DATA_WIDTH/8-1:0] wd_strb,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_resp,
    output logic [ID_WIDTH-1:0]     rsp_id,
    axi4_if.master                  axi
);
    localparam logic [2:0] SIZE = size_from_width(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_RSP
    } state_t;

    state_t state, nstate;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [1:0]            resp_q;
    logic [ID_WIDTH-1:0]   rspid_q;

    logic       cmd_hs, w_hs, r_hs, b_hs;
    logic       last;
    logic       rd_err;
    logic [1:0] rd_code, b_code;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign w_hs   = (state == S_W) && wd_valid && axi.wready;
    assign r_hs   = (state == S_R) && axi.rvalid && rd_ready;
    assign b_hs   = (state == S_B) && axi.bvalid;

    axi_beat_counter u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (cmd_hs),
        .inc    (w_hs || r_hs),
        .len    (len_q),
        .last   (last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE: if (cmd_valid)
                        nstate = cmd_write ? S_AW : S_AR;
            S_AW:   if (axi.awready) nstate = S_W;
            S_W:    if (w_hs && last) nstate = S_B;
            S_B:    if (axi.bvalid) nstate = S_RSP;
            S_AR:   if (axi.arready) nstate = S_R;
            S_R:    if (r_hs && axi.rlast) nstate = S_RSP;
            S_RSP:  if (rsp_ready) nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // Length error covers both an early rlast and a missing one at beat len.
    assign rd_err  = (axi.rid != id_q) || (axi.rlast != last);
    assign rd_code = (axi.rresp != RESP_OKAY) ? axi.rresp :
                     rd_err ? RESP_SLVERR : RESP_OKAY;
    assign b_code  = (axi.bid != id_q) ? RESP_SLVERR : axi.bresp;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            resp_q  <= RESP_OKAY;
            rspid_q <= '0;
        end else begin
            if (cmd_hs) begin
                addr_q  <= cmd_addr;
                len_q   <= cmd_len;
                id_q    <= cmd_id;
                resp_q  <= RESP_OKAY;
                rspid_q <= '0;
            end
            if (b_hs) begin
                resp_q  <= b_code;
                rspid_q <= axi.bid;
            end
            if (r_hs) begin
                if (resp_q == RESP_OKAY)
                    resp_q <= rd_code;
                if (axi.rlast)
                    rspid_q <= axi.rid;
            end
        end
    end

    assign cmd_ready = (state == S_IDLE);

    assign axi.awvalid  = (state == S_AW);
    assign axi.awid     = id_q;
    assign axi.awaddr   = addr_q;
    assign axi.awlen    = len_q;
    assign axi.awsize   = SIZE;
    assign axi.awburst  = BURST_INCR;
    assign axi.awlock   = 1'b0;
    assign axi.awcache  = 4'd0;
    assign axi.awprot   = 3'd0;
    assign axi.awqos    = 4'd0;
    assign axi.awregion = 4'd0;

    assign axi.wvalid = (state == S_W) && wd_valid;
    assign wd_ready   = (state == S_W) && axi.wready;
    assign axi.wdata  = wd_data;
    assign axi.wstrb  = wd_strb;
    assign axi.wlast  = last;
    assign axi.bready = (state == S_B);

    assign axi.arvalid  = (state == S_AR);
    assign axi.arid     = id_q;
    assign axi.araddr   = addr_q;
    assign axi.arlen    = len_q;
    assign axi.arsize   = SIZE;
    assign axi.arburst  = BURST_INCR;
    assign axi.arlock   = 1'b0;
    assign axi.arcache  = 4'd0;
    assign axi.arprot   = 3'd0;
    assign axi.arqos    = 4'd0;
    assign axi.arregion = 4'd0;

    assign rd_valid  = (state == S_R) && axi.rvalid;
    assign axi.rready = (state == S_R) && rd_ready;
    assign rd_data   = axi.rdata;
    assign rd_last   = axi.rlast;

    assign rsp_valid = (state == S_RSP);
    assign rsp_resp  = resp_q;
    assign rsp_id    = rspid_q;

    logic [16:0] span_end;
    assign span_end = 17'(cmd_addr[11:0]) +
                      ((17'(cmd_len) + 17'd1) << SIZE);

    // Requester must split bursts at 4 KB pages.
    a_no_4k_cross: assert property (
        @(posedge clk) disable iff (!resetn)
        cmd_hs |-> span_end <= 17'd4096
    );

endmodule

// File: tb/tb_axi_cmd_master.sv
// Directed bench for axi_cmd_master: table of bursts against an
// in-bench AXI target model, plus reset sequences.
module tb_axi_cmd_master;
    import axi4_pkg::*;

    logic        clk;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic        wd_valid, wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [63:0] rd_data;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_resp;
    logic [3:0]  rsp_id;

    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) bus ();

    axi_cmd_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wd_valid(wd_valid), .wd_ready(wd_ready),
        .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_resp(rsp_resp), .rsp_id(rsp_id),
        .axi(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
        logic [63:0] data;
        logic [7:0]  strb;
        int          err_beat;
        logic [1:0]  err_resp;
        int          last_beat;
        bit          id_bad;
        bit          stall;
        int          rst_at;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    task automatic chk(input int idx, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL v%0d %s: got %0h expected %0h", idx, nm, act, exp);
        end
    endtask

    function automatic bit rdy(input bit stall);
        return stall ? ($urandom_range(0, 2) == 0) : 1'b1;
    endfunction

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0;
        cmd_len = '0; cmd_id = '0;
        wd_valid = 0; wd_data = '0; wd_strb = '0;
        rd_ready = 0; rsp_ready = 0;
        bus.awready = 0; bus.wready = 0; bus.arready = 0;
        bus.bvalid = 0; bus.bid = '0; bus.bresp = '0;
        bus.rvalid = 0; bus.rid = '0; bus.rdata = '0;
        bus.rresp = '0; bus.rlast = 0;
    endtask

    function automatic logic [7:0] all_valids();
        return {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
                bus.rready, rd_valid, rsp_valid, wd_ready};
    endfunction

    task automatic run(input vec_t v, input int idx);
        int  wn, rn, cyc, lat, aw_n, ar_n;
        bit  fin, bp, rfin, wdp, rvp, aw_st, rsp_st;
        bit  w_hs, r_hs, b_hs, a_hs;
        logic [31:0] paddr;
        logic [1:0]  presp;
        logic [3:0]  xid;
        wn = 0; rn = 0; cyc = 0; lat = -1; aw_n = 0; ar_n = 0;
        fin = 0; bp = 0; rfin = 0; wdp = 0; rvp = 0;
        aw_st = 0; rsp_st = 0; paddr = '0; presp = '0;
        xid = v.id_bad ? (v.id ^ 4'h1) : v.id;

        @(negedge clk);
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_len = v.len; cmd_id = v.id;
        #1 chk(idx, "cmd_ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;

        for (int c = 0; c < 400 && !fin; c++) begin
            bus.awready = rdy(v.stall);
            bus.arready = rdy(v.stall);
            bus.wready  = rdy(v.stall);
            rd_ready    = rdy(v.stall);
            rsp_ready   = rdy(v.stall);
            if (!wdp)
                wd_valid = v.wr && wn <= int'(v.len) && rdy(v.stall);
            wd_data = v.data + 64'(wn);
            wd_strb = v.strb;
            bus.bvalid = bp;
            bus.bid    = xid;
            bus.bresp  = v.err_resp;
            if (!rvp)
                bus.rvalid = !v.wr && ar_n > 0 && !rfin && rdy(v.stall);
            bus.rdata = v.data + 64'(rn);
            bus.rresp = (rn == v.err_beat) ? v.err_resp : RESP_OKAY;
            bus.rlast = (rn == v.last_beat);
            bus.rid   = xid;
            #1;
            if (v.rst_at >= 0 && wn == v.rst_at && wd_valid) begin
                chk(idx, "wvalid_pre_rst", bus.wvalid, 1);
                resetn = 0;
                #1 chk(idx, "valids_in_rst", all_valids(), 0);
                idle_inputs();
                @(posedge clk);
                @(negedge clk);
                resetn = 1;
                #1 chk(idx, "cmd_ready_post_rst", cmd_ready, 1);
                chk(idx, "rsp_valid_post_rst", rsp_valid, 0);
                return;
            end
            if (lat < 0 && rsp_valid) lat = cyc + 1;
            if (aw_st)
                chk(idx, "addr_stable",
                    v.wr ? bus.awaddr : bus.araddr, paddr);
            if (rsp_st)
                chk(idx, "rsp_stable", rsp_resp, presp);
            a_hs = v.wr ? (bus.awvalid && bus.awready)
                        : (bus.arvalid && bus.arready);
            if (a_hs) begin
                if (v.wr) begin
                    chk(idx, "awaddr", bus.awaddr, v.addr);
                    chk(idx, "awlen", bus.awlen, v.len);
                    chk(idx, "awsize_burst",
                        {bus.awsize, bus.awburst}, {3'd3, 2'b01});
                    chk(idx, "awid", bus.awid, v.id);
                    chk(idx, "aw_side", {bus.awlock, bus.awcache,
                        bus.awprot, bus.awqos, bus.awregion}, 0);
                end else begin
                    chk(idx, "araddr", bus.araddr, v.addr);
                    chk(idx, "arlen", bus.arlen, v.len);
                    chk(idx, "arsize_burst",
                        {bus.arsize, bus.arburst}, {3'd3, 2'b01});
                    chk(idx, "arid", bus.arid, v.id);
                end
            end
            aw_st = v.wr ? (bus.awvalid && !bus.awready)
                         : (bus.arvalid && !bus.arready);
            paddr = v.wr ? bus.awaddr : bus.araddr;
            w_hs = bus.wvalid && bus.wready;
            if (w_hs) begin
                chk(idx, "wdata", bus.wdata, v.data + 64'(wn));
                chk(idx, "wstrb", bus.wstrb, v.strb);
                chk(idx, "wlast", bus.wlast, wn == int'(v.len));
            end
            b_hs = bus.bvalid && bus.bready;
            r_hs = bus.rvalid && bus.rready;
            if (r_hs) begin
                chk(idx, "rd_valid", rd_valid, 1);
                chk(idx, "rd_data", rd_data, v.data + 64'(rn));
                chk(idx, "rd_last", rd_last, rn == v.last_beat);
            end
            if (rsp_valid && rsp_ready) begin
                chk(idx, "rsp_resp", rsp_resp, v.exp_resp);
                chk(idx, "rsp_id", rsp_id, xid);
                fin = 1;
            end
            rsp_st = rsp_valid && !rsp_ready;
            presp = rsp_resp;
            @(posedge clk);
            cyc++;
            if (a_hs) begin
                if (v.wr) aw_n++;
                else ar_n++;
            end
            wdp = wd_valid && !w_hs;
            if (w_hs) begin
                wn++;
                if (wn == int'(v.len) + 1) bp = 1;
            end
            if (b_hs) bp = 0;
            rvp = bus.rvalid && !r_hs;
            if (r_hs) begin
                if (rn == v.last_beat) rfin = 1;
                rn++;
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk(idx, "completed", fin, 1);
        chk(idx, "addr_count", v.wr ? aw_n : ar_n, 1);
        if (v.wr) chk(idx, "w_beats", wn, int'(v.len) + 1);
        else      chk(idx, "r_beats", rn, v.last_beat + 1);
        if (v.exp_lat > 0) chk(idx, "latency", lat, v.exp_lat);
        chk(idx, "cmd_ready_after", cmd_ready, 1);
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1, 32'h1000, 8'd0, 4'h5, 64'hDEADBEEF, 8'hFF,
                     -1, RESP_OKAY, 0, 0, 0, -1, RESP_OKAY, 4};
        vecs[1]  = '{0, 32'h2000, 8'd7, 4'h3, 64'h1111_0000, 8'hFF,
                     -1, RESP_OKAY, 7, 0, 0, -1, RESP_OKAY, 10};
        vecs[2]  = '{1, 32'h3000, 8'd3, 4'h2, 64'hA5A5_0000_0000_0000,
                     8'h0F, -1, RESP_OKAY, 3, 0, 1, -1, RESP_OKAY, 0};
        vecs[3]  = '{0, 32'h4000, 8'd5, 4'h9, 64'h4000, 8'hFF,
                     2, RESP_DECERR, 5, 0, 1, -1, RESP_DECERR, 0};
        vecs[4]  = '{0, 32'h5000, 8'd3, 4'h1, 64'h5000, 8'hFF,
                     -1, RESP_OKAY, 1, 0, 0, -1, RESP_SLVERR, 0};
        vecs[5]  = '{1, 32'h6000, 8'd1, 4'h7, 64'h6000, 8'hF0,
                     -1, RESP_OKAY, 1, 1, 0, -1, RESP_SLVERR, 0};
        vecs[6]  = '{0, 32'h7000, 8'd2, 4'hA, 64'h7000, 8'hFF,
                     -1, RESP_OKAY, 4, 0, 1, -1, RESP_SLVERR, 0};
        vecs[7]  = '{1, 32'h8000, 8'd0, 4'hC, 64'h8000, 8'hFF,
                     -1, RESP_EXOKAY, 0, 0, 0, -1, RESP_EXOKAY, 0};
        vecs[8]  = '{0, 32'h9000, 8'd1, 4'h4, 64'h9000, 8'hFF,
                     -1, RESP_OKAY, 1, 1, 0, -1, RESP_SLVERR, 0};
        vecs[9]  = '{1, 32'hA000, 8'd3, 4'h6, 64'hA000, 8'hFF,
                     -1, RESP_OKAY, 3, 0, 0, 1, RESP_OKAY, 0};
        vecs[10] = '{1, 32'hB000, 8'd2, 4'h8, 64'hB000, 8'hFF,
                     -1, RESP_OKAY, 2, 0, 1, -1, RESP_OKAY, 0};
        vecs[11] = '{0, 32'hC000, 8'd3, 4'h2, 64'hC000, 8'hFF,
                     0, RESP_DECERR, 2, 0, 1, -1, RESP_DECERR, 0};

        idle_inputs();
        resetn = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 chk(-1, "valids_in_reset", all_valids(), 0);
        resetn = 1;
        #1;
        chk(-1, "cmd_ready_reset", cmd_ready, 1);
        chk(-1, "rsp_resp_reset", rsp_resp, 0);
        chk(-1, "rsp_id_reset", rsp_id, 0);

        for (int i = 0; i < 12; i++)
            run(vecs[i], i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_cmd_master.md
# axi_cmd_master

Synthesizable AXI4 initiator that turns simple command, write-data and read-data streams into AXI4 INCR bursts on the initiator side of an `axi4_if`. It is the counterpart of `axi_slave`: it replaces the bus-functional master in gate-level and emulation builds, and it gives SoC-level blocks (DMA, boot loaders) a bus master. It keeps one transaction outstanding at a time.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width; must match the `axi4_if` instance.
- DATA_WIDTH, 64, data width in bits (power of 2, 8..1024); must match the `axi4_if` instance.
- ID_WIDTH, 4, transaction ID width; must match the `axi4_if` instance.

Ports:
- clk  in  1  single clock; all logic is clocked on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted; equals 1 only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  burst start address; aligned to DATA_WIDTH/8.
- cmd_len  in  8  beats minus 1 (0..255).
- cmd_id  in  ID_WIDTH  AXI ID for the burst.
- wd_valid / wd_ready  in / out  1  write-data stream handshake.
- wd_data  in  DATA_WIDTH  write beat data.
- wd_strb  in  DATA_WIDTH/8  write beat byte strobes.
- rd_valid / rd_ready  out / in  1  read-data stream handshake.
- rd_data  out  DATA_WIDTH  read beat data.
- rd_last  out  1  last read beat.
- rsp_valid / rsp_ready  out / in  1  completion handshake.
- rsp_resp  out  2  final response code.
- rsp_id  out  ID_WIDTH  ID of the completed burst.
- axi  modport  —  initiator-side modport of `axi4_if`.

## Operation
- FSM states and transitions:
  - IDLE: on command handshake, go to AW if cmd_write=1, else AR.
  - AW: go to W on awready.
  - W: go to B on the wlast handshake.
  - B: go to RSP on bvalid.
  - AR: go to R on arready.
  - R: go to RSP on the rlast handshake.
  - RSP: go to IDLE on rsp_ready.
- The command is registered on the handshake. The registered copy drives the AW/AR fields:
  - addr = cmd_addr, len = cmd_len, id = cmd_id;
  - size = log2(DATA_WIDTH/8), burst = INCR (2'b01).
  - All other AW/AR sideband signals are driven to 0.
- awvalid/arvalid are registered and asserted only in AW/AR. Payload is held stable until ready. Valid never depends on ready.
- W state:
  - wvalid = wd_valid, wd_ready = wready, wdata/wstrb pass straight through (zero latency).
  - wlast = (beat count == len).
  - The upstream producer must keep wd_valid and its payload stable until wd_ready.
- R state:
  - rd_valid = rvalid, rready = rd_ready, rd_data = rdata, rd_last = rlast.
- 9-bit beat counter: cleared on command accept, incremented on each W/R handshake.
- Response:
  - Write: rsp_resp = bresp; rsp_id = bid.
  - Read: rsp_resp holds the first non-OKAY rresp seen, otherwise OKAY; rsp_id = rid of the last beat.
  - Read length error: rlast before beat len, or no rlast at beat len, reports SLVERR. On the no-rlast case the block keeps consuming beats until rlast.
  - bid/rid mismatch with cmd_id also reports SLVERR.
- Bursts must not cross a 4 KB boundary. This is the requester's responsibility and is checked by an assertion, not by logic.
- Outside W/R, the stream ready/valid outputs are 0.

## Timing
- Reset values: awvalid, wvalid, bready, arvalid, rready, rd_valid, rsp_valid, wd_ready = 0. cmd_ready = 1 once resetn is high. Counters and response registers = 0.
- Asserting resetn mid-burst abandons the transaction and drops every valid asynchronously. No completion is reported.
- Command handshake at edge N → awvalid/arvalid high in cycle N+1.
- Address handshake at edge M → state W/R from cycle M+1.
- bready = 1 throughout B.
- Last data or B handshake at edge K → rsp_valid in cycle K+1.
- rsp_valid is held until rsp_ready. cmd_ready returns the cycle after the rsp handshake.
- Single-beat write against an always-ready slave: 4 cycles from command to rsp_valid, plus slave B latency.

## Structure
- Shared `axi4_pkg` holds:
  - BURST_FIXED/INCR/WRAP;
  - RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - function size_from_width(DATA_WIDTH).
- The state enum stays local to the module.
- One natural sub-module: `axi_beat_counter` (clear, increment, compare-to-len, last flag). It is shared with the slave side.

## Test plan
- Write: addr 0x1000, len 0, data 0xDEADBEEF, strb 0xFF, OKAY slave → one AW (awlen=0, awsize=3, awburst=1), one W with wlast=1, rsp_resp=OKAY, rsp_id=cmd_id.
- Read burst: addr 0x2000, len 7 → eight rd beats, rd_last only on beat 8, rsp_resp=OKAY.
- Backpressure: random awready/wready/rready/rsp_ready stalls of 0–5 cycles → payloads stable while valid && !ready, data order intact.
- Error: slave returns rresp=DECERR on beat 3 of len 5 → rsp_resp=DECERR. Slave drives rlast on beat 2 of len 3 → SLVERR.
- ID mismatch: bid ≠ cmd_id → rsp_resp=SLVERR.
- Reset: resetn low during W beat 2 of len 3 → all valids drop at once, cmd_ready=1 after release, next write completes OKAY.
